// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcode/funct values and R-type field positions.
// Pure definitions, no logic.
package mips_pkg;

   localparam logic [5:0]  OP_RTYPE  = 6'h00;
   localparam logic [5:0]  FUNCT_ADD = 6'h20;
   localparam logic [5:0]  FUNCT_SUB = 6'h22;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;

   localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/rtype_field_decode.sv
// Combinational R-type field slicer; zero latency, no handshake (pure decode).
// Shared with the datapath decode stage.
module rtype_field_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic        is_rtype
);

   assign rs       = instr[RS_LSB    +: 5];
   assign rt       = instr[RT_LSB    +: 5];
   assign rd       = instr[RD_LSB    +: 5];
   assign shamt    = instr[SHAMT_LSB +: 5];
   assign funct    = instr[FUNCT_LSB +: 6];
   assign is_rtype = (instr[OPCODE_LSB +: 6] == OP_RTYPE);

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-to-datapath FIFO with first-word fall-through; push visible one cycle later.
// in_ready drops when full (no same-cycle pop bypass); flush empties the queue.
module instr_prefetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic              out_is_rtype,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [PC_W-1:0]   mem_pc    [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              dec_is_rtype;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   assign out_instr = out_valid ? mem_instr[rd_ptr] : DATA_W'(NOP);
   assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

   rtype_field_decode u_decode (
      .instr    (out_instr[31:0]),
      .rs       (out_rs),
      .rt       (out_rt),
      .rd       (out_rd),
      .shamt    (out_shamt),
      .funct    (out_funct),
      .is_rtype (dec_is_rtype)
   );

   // A zeroed empty head decodes as opcode 0, so qualify it.
   assign out_is_rtype = dec_is_rtype && out_valid;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed table, corner sequences, random vs queue model.
module tb_instr_prefetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_is_rtype;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
   logic [5:0]  out_funct;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_prefetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
      .out_funct(out_funct), .out_is_rtype(out_is_rtype), .count(count)
   );

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic [2:0]  exp_cnt;
      logic        exp_ir;
      logic        exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                               input logic [2:0] c, input logic ir, input logic ov,
                               input logic [31:0] opc);
      vec_t v;
      v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.exp_cnt = c; v.exp_ir = ir; v.exp_ov = ov; v.exp_pc = opc;
      return v;
   endfunction

   vec_t   tbl[10];
   entry_t model_q[$];

   initial begin
      tbl[0] = mk(1, 4,  0, 2, 1, 1, 0);
      tbl[1] = mk(1, 8,  0, 3, 1, 1, 0);
      tbl[2] = mk(1, 12, 0, 4, 0, 1, 0);
      tbl[3] = mk(1, 16, 0, 4, 0, 1, 0);   // full: word held
      tbl[4] = mk(1, 16, 0, 4, 0, 1, 0);
      tbl[5] = mk(0, 0,  1, 3, 1, 1, 4);
      tbl[6] = mk(0, 0,  1, 2, 1, 1, 8);
      tbl[7] = mk(0, 0,  1, 1, 1, 1, 12);
      tbl[8] = mk(0, 0,  1, 0, 1, 0, 0);
      tbl[9] = mk(0, 0,  1, 0, 1, 0, 0);   // pop while empty: no effect

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;

      // Reset, then a single SUB push
      step(); step();
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_is_rtype", out_is_rtype, 0);
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; in_instr = 32'h01E9A022; in_pc = 32'd0;
      step();
      chk("sub_valid", out_valid, 1);
      chk("sub_rs", out_rs, 15);
      chk("sub_rt", out_rt, 9);
      chk("sub_rd", out_rd, 20);
      chk("sub_funct", out_funct, 6'h22);
      chk("sub_is_rtype", out_is_rtype, 1);
      chk("sub_count", count, 1);

      // Fill, overflow and drain from the table
      for (int i = 0; i < 10; i++) begin
         in_valid  = tbl[i].iv;
         in_pc     = tbl[i].pc;
         in_instr  = 32'h1000_0000 | tbl[i].pc;
         out_ready = tbl[i].ordy;
         step();
         chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_ir);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
         chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].exp_pc);
      end

      // ADD lands in slot 0 after pointer wrap
      in_valid = 1'b1; in_instr = 32'h00AF7820; in_pc = 32'd16; out_ready = 1'b0;
      step();
      chk("add_instr", out_instr, 32'h00AF7820);
      chk("add_pc", out_pc, 16);
      chk("add_rs", out_rs, 5);
      chk("add_rt", out_rt, 15);
      chk("add_rd", out_rd, 15);
      chk("add_funct", out_funct, 6'h20);

      // Simultaneous push/pop at count 2
      in_instr = 32'h0; in_pc = 32'd20;
      step();
      chk("pp_pre_count", count, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_pc = 32'd24 + 32'(4 * i);
         step();
         chk($sformatf("pp%0d_count", i), count, 2);
         chk($sformatf("pp%0d_pc", i), out_pc, 32'd20 + 32'(4 * i));
      end

      // Flush at count 3 together with push and pop
      out_ready = 1'b0; in_pc = 32'd48;
      step();
      chk("fl_pre_count", count, 3);
      flush = 1'b1; out_ready = 1'b1; in_pc = 32'hDEAD0;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("fl_count", count, 0);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      step();
      chk("fl_word_absent", out_valid, 0);
      in_valid = 1'b1; in_pc = 32'h100;
      step();
      chk("fl_next_pc", out_pc, 32'h100);
      chk("fl_next_count", count, 1);

      // Asynchronous reset between edges at count 2
      in_pc = 32'h104;
      step();
      in_valid = 1'b0;
      chk("ar_pre_count", count, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", count, 0);
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_instr", out_instr, 0);
      chk("ar_out_pc", out_pc, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("ar_post_count", count, 0);
      in_valid = 1'b1; in_instr = 32'h00AF7820; in_pc = 32'h200;
      step();
      in_valid = 1'b0;
      chk("ar_push_valid", out_valid, 1);
      chk("ar_push_pc", out_pc, 32'h200);

      // Randomized traffic against a queue model
      flush = 1'b1;
      step();
      flush = 1'b0;
      model_q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic   m_push, m_pop;
         entry_t e, h;
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(40) == 0);
         e.instr   = $urandom;
         if ($urandom_range(1) == 1) e.instr[31:26] = 6'h00;
         e.pc      = $urandom;
         in_instr  = e.instr;
         in_pc     = e.pc;
         m_push = in_valid && (model_q.size() < DEPTH);
         m_pop  = out_ready && (model_q.size() > 0);
         step();
         if (flush) model_q.delete();
         else begin
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back(e);
         end
         if (model_q.size() > 0) h = model_q[0];
         else begin h.instr = 32'h0; h.pc = 32'h0; end
         chk("rnd_count", count, model_q.size());
         chk("rnd_in_ready", in_ready, model_q.size() < DEPTH);
         chk("rnd_out_valid", out_valid, model_q.size() > 0);
         chk("rnd_out_instr", out_instr, h.instr);
         chk("rnd_out_pc", out_pc, h.pc);
         chk("rnd_out_rd", out_rd, h.instr[15:11]);
         chk("rnd_is_rtype", out_is_rtype, (model_q.size() > 0) && (h.instr[31:26] == 6'h00));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Decoupling buffer between the instruction fetch stage and the R-type datapath.
- Accepts {instruction, PC} pairs from fetch over a valid/ready handshake and stores them in a DEPTH-entry circular FIFO.
- Presents the head entry to the datapath with R-type fields pre-sliced, so a stalled datapath never loses a fetched word.
- A flush input discards all buffered instructions. It is used on redirect.

Parameters:
- DEPTH, 4, number of entries. Must be a power of two and at least 2.
- DATA_W, 32, instruction width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue can accept a word.
- in_instr  in  DATA_W  fetched instruction.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  datapath consumes the head this cycle.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  PC_W  head PC.
- out_rs, out_rt, out_rd, out_shamt  out  5 each  head bits [25:21], [20:16], [15:11], [10:6].
- out_funct  out  6  head bits [5:0].
- out_is_rtype  out  1  head opcode [31:26] == OP_RTYPE, qualified by out_valid.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0 and in_ready=1.
  - out_instr, out_pc and all field outputs read 0. This equals the NOP encoding.
  - Storage contents are don't-care.
  - Reset may assert mid-transfer. The transfer in progress is lost and no partial state survives.
- Push: occurs when in_valid && in_ready at the clock edge.
  - Writes {in_instr, in_pc} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at the clock edge. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). No full-bypass: when full, in_ready is 0 even if a pop happens the same cycle.
- out_valid = (count != 0). Outputs are a combinational read of the entry at rd_ptr (first-word fall-through).
- Latency: a word pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no empty-queue bypass.
- When empty, out_instr, out_pc and the field outputs are forced to 0. out_is_rtype is forced to 0, not 1.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, legal whenever 0 < count < DEPTH.
  - count never exceeds DEPTH and never wraps below 0. Handshake gating guarantees this.
- in_valid while full: the word is not taken. Fetch must hold in_instr/in_pc until in_ready.
- out_ready while empty: no effect.
- Flush (synchronous, highest priority):
  - At the edge, pointers and count go to 0.
  - A push and/or pop in the same cycle are discarded, so the flushed-cycle word is not enqueued.
  - The cycle after flush has out_valid=0 and in_ready=1.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty status comes from count, not from pointer comparison.

Decomposition:
- Shared package mips_pkg:
  - OP_RTYPE=6'h00, FUNCT_ADD=6'h20, FUNCT_SUB=6'h22.
  - Field bit-position constants for rs/rt/rd/shamt/funct.
  - A NOP constant of 32'h0.
- One combinational sub-module, rtype_field_decode: slices an instruction word into rs/rt/rd/shamt/funct/is_rtype. It is reused later by the datapath decode.

Test Plan:
- Reset then single push: hold rst_n=0 for 2 cycles and check count=0, out_valid=0, out_instr=0. Release, push 32'h01E9A022 with PC 0 (Sub $20,$15,$9), out_ready=0. Next cycle: out_valid=1, out_rs=15, out_rt=9, out_rd=20, out_funct=6'h22, out_is_rtype=1, count=1.
- Fill and overflow: push 5 words (PC 0,4,8,12,16) with out_ready=0. After 4 accepts: count=4, in_ready=0. The 5th word is held and count stays at 4.
- Order and wrap: drain the 4 entries with out_ready=1. out_pc must read 0,4,8,12. Then push 32'h00AF7820 (Add $15,$5,$15) at PC 16, landing in slot 0 after the wrap. Check out_rs=5, out_rt=15, out_rd=15, out_funct=6'h20.
- Simultaneous push/pop: with count=2, assert push and pop for 6 consecutive cycles. count must hold at 2 and out_pc must advance by 4 each cycle.
- Flush: with count=3, assert flush together with in_valid=1 and out_ready=1. Next cycle: count=0, out_valid=0, in_ready=1, and the flushed-cycle word is absent.
- Asynchronous reset mid-stream: with count=2, drop rst_n between clock edges. Outputs go to 0 immediately, without waiting for an edge. After release, the first new push reappears in cycle N+1.
